// File: rtl/timer_share_ctrl_if.sv
// rtl/timer_share_ctrl_if.sv - APB link between the timer share controller and the timer slave
interface timer_share_ctrl_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] m_paddr;
    logic [31:0]           m_pwdata;
    logic                  m_pwrite;
    logic                  m_psel;
    logic                  m_penable;
    logic [31:0]           m_prdata;
    logic                  m_pready;
    logic                  m_pslverr;

    modport master (
        output m_paddr, m_pwdata, m_pwrite, m_psel, m_penable,
        input  m_prdata, m_pready, m_pslverr
    );

    modport slave (
        input  m_paddr, m_pwdata, m_pwrite, m_psel, m_penable,
        output m_prdata, m_pready, m_pslverr
    );
endinterface

// File: rtl/timer_share_ctrl.sv
// rtl/timer_share_ctrl.sv - shares one APB timer among NUM_REQ one-shot delay requesters
module timer_share_ctrl #(
    parameter int                        NUM_REQ        = 4,
    parameter int                        APB_ADDR_WIDTH = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] TIMER_BASE     = '0
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [NUM_REQ*32-1:0]   ticks_i,
    input  logic [NUM_REQ*3-1:0]    presc_i,
    input  logic [NUM_REQ-1:0]      cancel_i,
    output logic [NUM_REQ-1:0]      gnt_o,
    output logic [NUM_REQ-1:0]      busy_o,
    output logic [NUM_REQ-1:0]      done_o,
    output logic [NUM_REQ-1:0]      abort_o,
    output logic [31:0]             elapsed_o,
    timer_share_ctrl_if.master      m_apb,
    input  logic [1:0]              timer_irq_i
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [APB_ADDR_WIDTH-1:0] OFF_TIMER = APB_ADDR_WIDTH'(0);
    localparam logic [APB_ADDR_WIDTH-1:0] OFF_CTRL  = APB_ADDR_WIDTH'(4);
    localparam logic [APB_ADDR_WIDTH-1:0] OFF_CMP   = APB_ADDR_WIDTH'(8);

    typedef enum logic [2:0] {
        S_IDLE, S_ZERO, S_WR_CTRL, S_WR_CMP, S_WAIT, S_RD_TIMER, S_WR_DIS
    } state_t;

    state_t                    state_q, state_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      pwrite_q, pwrite_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic [IDX_W-1:0]          active_q, active_d;
    logic [IDX_W-1:0]          rr_q, rr_d;
    logic [31:0]               ticks_q, ticks_d;
    logic                      pend_abort_q, pend_abort_d;
    logic [31:0]               elapsed_q, elapsed_d;
    logic [NUM_REQ-1:0]        gnt_q, gnt_d;
    logic [NUM_REQ-1:0]        busy_q, busy_d;
    logic [NUM_REQ-1:0]        done_q, done_d;
    logic [NUM_REQ-1:0]        abort_q, abort_d;

    logic [31:0]               ticks_arr [NUM_REQ];
    logic [2:0]                presc_arr [NUM_REQ];
    logic                      found;
    logic [IDX_W-1:0]          pick;
    logic [IDX_W-1:0]          pick_next;
    logic                      xfer_done;
    logic                      start_xfer;
    logic [APB_ADDR_WIDTH-1:0] xfer_off;
    logic [31:0]               xfer_wdata;
    logic                      xfer_write;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] k);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Unpack the per-requester delay and prescaler slices.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            ticks_arr[i] = ticks_i[32*i +: 32];
            presc_arr[i] = presc_i[3*i +: 3];
        end
    end

    // Round-robin pick: first active request at or after the pointer, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_i[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDX_W-1:0];
            end
        end
        pick_next = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
    end

    assign xfer_done = psel_q & penable_q & m_apb.m_pready;

    // Sequencer: next state, APB phase control and completion pulses.
    always_comb begin
        state_d      = state_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        active_d     = active_q;
        rr_d         = rr_q;
        ticks_d      = ticks_q;
        pend_abort_d = pend_abort_q;
        elapsed_d    = elapsed_q;
        gnt_d        = '0;
        done_d       = '0;
        abort_d      = '0;
        busy_d       = busy_q & ~(done_q | abort_q);
        start_xfer   = 1'b0;
        xfer_off     = OFF_CTRL;
        xfer_wdata   = '0;
        xfer_write   = 1'b1;

        if (psel_q && !penable_q) penable_d = 1'b1;

        if (xfer_done && m_apb.m_pslverr && state_q != S_WR_DIS) begin
            // A failed transfer still has to leave the timer disabled.
            state_d      = S_WR_DIS;
            pend_abort_d = 1'b1;
            elapsed_d    = '0;
            start_xfer   = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (found) begin
                        active_d     = pick;
                        rr_d         = pick_next;
                        ticks_d      = ticks_arr[pick];
                        pend_abort_d = 1'b0;
                        gnt_d        = onehot(pick);
                        busy_d       = busy_d | onehot(pick);
                        if (ticks_arr[pick] == 32'd0) begin
                            state_d = S_ZERO;
                        end else begin
                            state_d    = S_WR_CTRL;
                            start_xfer = 1'b1;
                            xfer_wdata = {26'b0, presc_arr[pick], 3'b001};
                        end
                    end
                end
                S_ZERO: begin
                    // A zero compare value never matches, so finish without the timer.
                    done_d  = onehot(active_q);
                    state_d = S_IDLE;
                end
                S_WR_CTRL: begin
                    if (xfer_done) begin
                        state_d    = S_WR_CMP;
                        start_xfer = 1'b1;
                        xfer_off   = OFF_CMP;
                        xfer_wdata = ticks_q;
                    end
                end
                S_WR_CMP: begin
                    if (xfer_done) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (|timer_irq_i) begin
                        state_d    = S_WR_DIS;
                        start_xfer = 1'b1;
                    end else if (cancel_i[active_q]) begin
                        state_d    = S_RD_TIMER;
                        start_xfer = 1'b1;
                        xfer_off   = OFF_TIMER;
                        xfer_write = 1'b0;
                    end
                end
                S_RD_TIMER: begin
                    if (xfer_done) begin
                        elapsed_d    = m_apb.m_prdata;
                        pend_abort_d = 1'b1;
                        state_d      = S_WR_DIS;
                        start_xfer   = 1'b1;
                    end
                end
                S_WR_DIS: begin
                    if (xfer_done) begin
                        state_d = S_IDLE;
                        if (pend_abort_q || m_apb.m_pslverr) begin
                            abort_d = onehot(active_q);
                            if (m_apb.m_pslverr) elapsed_d = '0;
                        end else begin
                            done_d = onehot(active_q);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (xfer_done) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
        end
        if (start_xfer) begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            paddr_d   = TIMER_BASE + xfer_off;
            pwdata_d  = xfer_wdata;
            pwrite_d  = xfer_write;
        end
    end

    // State and output registers; reset drops the bus immediately.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= S_IDLE;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            active_q     <= '0;
            rr_q         <= '0;
            ticks_q      <= '0;
            pend_abort_q <= 1'b0;
            elapsed_q    <= '0;
            gnt_q        <= '0;
            busy_q       <= '0;
            done_q       <= '0;
            abort_q      <= '0;
        end else begin
            state_q      <= state_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            active_q     <= active_d;
            rr_q         <= rr_d;
            ticks_q      <= ticks_d;
            pend_abort_q <= pend_abort_d;
            elapsed_q    <= elapsed_d;
            gnt_q        <= gnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            abort_q      <= abort_d;
        end
    end

    assign gnt_o           = gnt_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign abort_o         = abort_q;
    assign elapsed_o       = elapsed_q;
    assign m_apb.m_psel    = psel_q;
    assign m_apb.m_penable = penable_q;
    assign m_apb.m_pwrite  = pwrite_q;
    assign m_apb.m_paddr   = paddr_q;
    assign m_apb.m_pwdata  = pwdata_q;
endmodule
